// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register-file geometry and word/address types.
// Reused by the register file, ALU and control blocks.
package mips_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         NUM_REGS = 32;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: read mux, $zero force and an
// optional write-to-read bypass for the ALU operand ports.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic [DW-1:0] mem [2**AW],
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    logic [DW-1:0] stored;

    assign stored = (addr == AW'(REG_ZERO)) ? '0 : mem[addr];

    generate
        if (BYPASS) begin : g_bypass
            logic hit;
            // A nonzero wr_addr match already excludes $zero, so the bypass
            // stays a single 2:1 mux behind the read mux.
            assign hit  = rst_n && wr_en && (wr_addr != AW'(REG_ZERO)) && (addr == wr_addr);
            assign data = hit ? wr_data : stored;
        end else begin : g_plain
            logic unused_wr;
            assign unused_wr = ^{rst_n, wr_en, wr_addr, wr_data};
            assign data      = stored;
        end
    endgenerate

endmodule

// File: rtl/register_file.sv
// 32 x 32 MIPS general-purpose register file: storage array and write logic,
// with two bypassed operand read ports and one stored-state debug port.
module register_file
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [AW-1:0] rs_addr_i,
    input  logic [AW-1:0] rt_addr_i,
    output logic [DW-1:0] data1_out,
    output logic [DW-1:0] data2_out,
    input  logic          RegWrite_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [DW-1:0] dbg_data_o
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0] mem [DEPTH];

    // Word 0 is never written, so it holds its reset value of zero forever.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (RegWrite_i && (wr_addr_i != AW'(REG_ZERO))) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    regfile_read_port #(.DW(DW), .AW(AW), .BYPASS(1'b1)) u_port1 (
        .mem     (mem),
        .rst_n   (rst_n_i),
        .wr_en   (RegWrite_i),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .addr    (rs_addr_i),
        .data    (data1_out)
    );

    regfile_read_port #(.DW(DW), .AW(AW), .BYPASS(1'b1)) u_port2 (
        .mem     (mem),
        .rst_n   (rst_n_i),
        .wr_en   (RegWrite_i),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .addr    (rt_addr_i),
        .data    (data2_out)
    );

    regfile_read_port #(.DW(DW), .AW(AW), .BYPASS(1'b0)) u_dbg (
        .mem     (mem),
        .rst_n   (rst_n_i),
        .wr_en   (RegWrite_i),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .addr    (dbg_addr_i),
        .data    (dbg_data_o)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed testbench for register_file: a register-array model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        reg_write;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    logic [31:0] model [32];

    register_file #(.DW(32), .AW(5)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .rs_addr_i  (rs_addr),
        .rt_addr_i  (rt_addr),
        .data1_out  (data1),
        .data2_out  (data2),
        .RegWrite_i (reg_write),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: registers as a plain array; reset empties it, a qualified write lands at the edge.
    always @(negedge rst_n) begin
        for (int i = 0; i < 32; i++) model[i] = '0;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1 && reg_write === 1'b1 && wr_addr != 5'd0)
            model[wr_addr] = wr_data;
    end

    function automatic logic [31:0] exp_port(input logic [4:0] a);
        if (rst_n !== 1'b1) return '0;
        if (a == 5'd0) return '0;
        if (reg_write === 1'b1 && wr_addr == a) return wr_data;
        return model[a];
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [4:0] a);
        if (rst_n !== 1'b1 || a == 5'd0) return '0;
        return model[a];
    endfunction

    always @(negedge clk) begin
        if (run_cmp) begin
            check("model_data1", data1, exp_port(rs_addr));
            check("model_data2", data2, exp_port(rt_addr));
            check("model_dbg", dbg_data, exp_dbg(dbg_addr));
        end
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        rst_n = 1'b1; reg_write = 1'b0; wr_addr = '0; wr_data = '0;
        rs_addr = '0; rt_addr = '0; dbg_addr = '0;
        #2 rst_n = 1'b0;
        #1 run_cmp = 1'b1;
        step(); step();
        check("reset_data1", data1, 32'h0);
        check("reset_dbg", dbg_data, 32'h0);
        rst_n = 1'b1;

        // Reset clears a stored word immediately and it stays cleared
        reg_write = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        reg_write = 1'b0; dbg_addr = 5'd5;
        settle();
        check("r5_written", dbg_data, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("r5_async_clear", dbg_data, 32'h0);
        #1 rst_n = 1'b1;
        step();
        check("r5_after_release", dbg_data, 32'h0);

        // $zero ignores writes and never bypasses
        reg_write = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs_addr = 5'd0; dbg_addr = 5'd0;
        settle();
        check("zero_same_cycle", data1, 32'h0);
        step();
        reg_write = 1'b0;
        settle();
        check("zero_after_edge", data1, 32'h0);
        check("zero_dbg", dbg_data, 32'h0);

        // Back-to-back writes then read
        reg_write = 1'b1; wr_addr = 5'd8; wr_data = 32'h00000007;
        step();
        wr_addr = 5'd9; wr_data = 32'hFFFFFFF9;
        step();
        reg_write = 1'b0; rs_addr = 5'd8; rt_addr = 5'd9;
        settle();
        check("read_r8", data1, 32'h00000007);
        check("read_r9", data2, 32'hFFFFFFF9);

        // Bypass on both operand ports, debug port shows the stored word
        reg_write = 1'b1; wr_addr = 5'd3; wr_data = 32'h11111111;
        step();
        wr_data = 32'h22222222; rs_addr = 5'd3; rt_addr = 5'd3; dbg_addr = 5'd3;
        settle();
        check("bypass_data1", data1, 32'h22222222);
        check("bypass_data2", data2, 32'h22222222);
        check("bypass_dbg_old", dbg_data, 32'h11111111);
        step();
        reg_write = 1'b0;
        settle();
        check("bypass_dbg_new", dbg_data, 32'h22222222);

        // Disabled write changes nothing
        reg_write = 1'b1; wr_addr = 5'd4; wr_data = 32'h12345678;
        step();
        reg_write = 1'b0; wr_data = 32'hAAAA5555; rs_addr = 5'd4; dbg_addr = 5'd4;
        settle();
        check("wdis_data1", data1, 32'h12345678);
        step();
        check("wdis_dbg", dbg_data, 32'h12345678);

        // Reset asserted with a write pending: the write is lost
        reg_write = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFEF00D; dbg_addr = 5'd7;
        settle();
        rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
        reg_write = 1'b0;
        settle();
        check("rst_write_lost", dbg_data, 32'h0);
        dbg_addr = 5'd4;
        settle();
        check("rst_cleared_r4", dbg_data, 32'h0);

        // Full sweep across all registers and all three ports
        step();
        reg_write = 1'b1;
        for (int i = 1; i < 32; i++) begin
            wr_addr = 5'(i);
            wr_data = 32'(i) * 32'h01010101;
            step();
        end
        reg_write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i); dbg_addr = 5'(i);
            settle();
            check("sweep_data1", data1, 32'(i) * 32'h01010101);
            check("sweep_data2", data2, 32'(31 - i) * 32'h01010101);
            check("sweep_dbg", dbg_data, 32'(i) * 32'h01010101);
            step();
        end

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
